// File: rtl/audio_adc_deserializer.sv
// audio_adc_deserializer: I2S ADC serial stream to parallel signed stereo samples
// Ports: state_clk/reset  - system clock, asynchronous active-high reset
//        bclk/lrck/adcdat - raw codec I2S signals, asynchronous to state_clk
//        audio_l/audio_r  - last complete stereo pair (two's complement)
//        sample_valid     - one-cycle strobe when audio_l/audio_r update
//        lr_clk           - synchronized lrck for the downstream filter
//        frame_err        - one-cycle strobe when a slot ends before WIDTH bits
module audio_adc_deserializer #(
    parameter int WIDTH = 16
) (
    input  logic                    state_clk,
    input  logic                    reset,
    input  logic                    bclk,
    input  logic                    lrck,
    input  logic                    adcdat,
    output logic signed [WIDTH-1:0] audio_l,
    output logic signed [WIDTH-1:0] audio_r,
    output logic                    sample_valid,
    output logic                    lr_clk,
    output logic                    frame_err
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       bclk_q, lrck_q, adcdat_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d, hold_q, hold_d;
    logic [WIDTH-1:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;
    logic             left_ok_q, left_ok_d, valid_q, valid_d, err_q, err_d;
    logic             rise, lr_edge;
    logic [WIDTH-1:0] word;

    // Sync chains are indexed [0]=s1, [1]=s2, [2]=s3
    assign rise    = bclk_q[1] & ~bclk_q[2];
    assign lr_edge = lrck_q[1] ^ lrck_q[2];
    assign word    = {shift_q[WIDTH-2:0], adcdat_q[1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        left_ok_d = left_ok_q;
        audio_l_d = audio_l_q;
        audio_r_d = audio_r_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (lr_edge) begin
            // A coincident bclk rise is already the new slot's delay bit
            state_d = rise ? SHIFT : SKIP;
            cnt_d   = '0;
            shift_d = '0;
            if (state_q == SKIP || state_q == SHIFT) begin
                err_d = 1'b1;
                if (!lrck_q[2]) left_ok_d = 1'b0;
            end
        end else if (rise) begin
            if (state_q == SKIP) begin
                state_d = SHIFT;
            end else if (state_q == SHIFT) begin
                shift_d = word;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = WAIT;
                    if (!lrck_q[2]) begin
                        hold_d    = word;
                        left_ok_d = 1'b1;
                    end else if (left_ok_q) begin
                        audio_l_d = hold_q;
                        audio_r_d = word;
                        valid_d   = 1'b1;
                        left_ok_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge state_clk or posedge reset) begin
        if (reset) begin
            bclk_q    <= '0;
            lrck_q    <= '0;
            adcdat_q  <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            left_ok_q <= 1'b0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bclk_q    <= {bclk_q[1:0], bclk};
            lrck_q    <= {lrck_q[1:0], lrck};
            adcdat_q  <= {adcdat_q[1:0], adcdat};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            left_ok_q <= left_ok_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign audio_l      = audio_l_q;
    assign audio_r      = audio_r_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
    assign lr_clk       = lrck_q[1];
endmodule

// File: tb/tb_audio_adc_deserializer.sv
// tb_audio_adc_deserializer: self-checking bench with a slot-level I2S reference model
module tb_audio_adc_deserializer;
    localparam int W = 16;

    typedef struct packed {
        logic [31:0]  t;
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_t;

    logic state_clk = 1'b0, reset = 1'b1, bclk = 1'b0, lrck = 1'b0, adcdat = 1'b0;
    logic signed [W-1:0] audio_l, audio_r;
    logic sample_valid, lr_clk, frame_err;

    int n_tests = 0, n_fail = 0, cyc = 0, dbl = 0, hold_bad = 0;
    pair_t got_pairs[$], exp_pairs[$];
    int got_err[$], exp_err[$];
    bit lrh [100000];
    logic pv = 1'b0, prst = 1'b1;
    logic [W-1:0] pl = '0, pr = '0;

    // Reference model state: last lrck value seen by the block, whether a slot is
    // being tracked, whether that slot was short, pending left word
    logic m_lr = 1'b0, m_trk = 1'b0, m_short = 1'b0, m_pend = 1'b0;
    logic [W-1:0] m_hold = '0;

    audio_adc_deserializer #(.WIDTH(W)) dut (
        .state_clk(state_clk), .reset(reset), .bclk(bclk), .lrck(lrck), .adcdat(adcdat),
        .audio_l(audio_l), .audio_r(audio_r), .sample_valid(sample_valid),
        .lr_clk(lr_clk), .frame_err(frame_err)
    );

    always #5 state_clk = ~state_clk;
    always @(posedge state_clk) cyc <= cyc + 1;

    always @(posedge state_clk) begin
        #1;
        if (cyc < 100000) lrh[cyc] = lr_clk;
        if (sample_valid) got_pairs.push_back(pair_t'({32'(cyc), audio_l, audio_r}));
        if (frame_err) got_err.push_back(cyc);
        if (sample_valid && pv) dbl++;
        if (!reset && !prst && !sample_valid && (audio_l !== pl || audio_r !== pr)) hold_bad++;
        pv = sample_valid;
        prst = reset;
        pl = audio_l;
        pr = audio_r;
    end

    // One I2S slot: lrck changes on falling bclk (or on the delay rise when simul),
    // one delay bit, then nbits data bits MSB first; the model is updated afterwards
    task automatic slot(input logic lr, input int nbits, input logic [63:0] data, input bit simul,
                        output int le, output int wr);
        logic [W-1:0] word;
        bit edge_seen;
        edge_seen = (lr != m_lr);
        le = 0;
        wr = 0;
        @(negedge state_clk);
        bclk = 1'b0;
        adcdat = 1'($urandom);
        if (!simul) begin lrck = lr; le = cyc + 1; end
        repeat (4) @(negedge state_clk);
        bclk = 1'b1;
        if (simul) begin lrck = lr; le = cyc + 1; end
        repeat (4) @(negedge state_clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            bclk = 1'b0;
            adcdat = data[i];
            repeat (4) @(negedge state_clk);
            bclk = 1'b1;
            if (i == nbits - W) wr = cyc + 1;
            repeat (4) @(negedge state_clk);
        end
        if (edge_seen) begin
            if (m_trk && m_short) begin
                exp_err.push_back(le + 2);
                if (!m_lr) m_pend = 1'b0;
            end
            m_trk = 1'b1;
        end
        m_lr = lr;
        m_short = (nbits < W);
        if (m_trk && nbits >= W) begin
            word = data[nbits-1 -: W];
            if (!lr) begin
                m_pend = 1'b1;
                m_hold = word;
            end else if (m_pend) begin
                exp_pairs.push_back(pair_t'({32'(wr + 2), m_hold, word}));
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        int le, wr, gb, eb;
        repeat (3) @(negedge state_clk);
        n_tests++; if (audio_l !== '0) begin n_fail++; $display("FAIL reset_audio_l: got %h expected 0", audio_l); end
        n_tests++; if (audio_r !== '0) begin n_fail++; $display("FAIL reset_audio_r: got %h expected 0", audio_r); end
        n_tests++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_tests++; if (lr_clk !== 1'b0) begin n_fail++; $display("FAIL reset_lr_clk: got %b expected 0", lr_clk); end
        gb = got_pairs.size();
        eb = got_err.size();
        reset = 1'b0;
        slot(1'b1, W + 1, {$urandom, $urandom}, 1'b0, le, wr);
        repeat (8) @(negedge state_clk);
        n_tests++; if (got_pairs.size() != gb) begin n_fail++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", got_pairs.size() - gb); end
        n_tests++; if (got_err.size() != eb) begin n_fail++; $display("FAIL reset_no_err: got %0d errors expected 0", got_err.size() - eb); end
    endtask

    task automatic test_basic();
        int le, wr, gb, eb;
        exp_pairs.delete(); exp_err.delete();
        gb = got_pairs.size();
        eb = got_err.size();
        slot(1'b0, W, 64'h1234, 1'b0, le, wr);
        slot(1'b1, W, 64'hABCD, 1'b0, le, wr);
        repeat (8) @(negedge state_clk);
        n_tests++; if (got_pairs.size() - gb != exp_pairs.size()) begin n_fail++; $display("FAIL basic_pulses: got %0d expected %0d", got_pairs.size() - gb, exp_pairs.size()); end
        else foreach (exp_pairs[i]) begin
            n_tests++;
            if (got_pairs[gb+i] !== exp_pairs[i]) begin n_fail++; $display("FAIL basic_pair: got t=%0d l=%h r=%h expected t=%0d l=%h r=%h", got_pairs[gb+i].t, got_pairs[gb+i].l, got_pairs[gb+i].r, exp_pairs[i].t, exp_pairs[i].l, exp_pairs[i].r); end
        end
        n_tests++; if (audio_l !== 16'h1234) begin n_fail++; $display("FAIL basic_audio_l: got %h expected 1234", audio_l); end
        n_tests++; if (audio_r !== 16'hABCD) begin n_fail++; $display("FAIL basic_audio_r: got %h expected abcd", audio_r); end
        n_tests++; if (got_err.size() != eb) begin n_fail++; $display("FAIL basic_no_err: got %0d errors expected 0", got_err.size() - eb); end
    endtask

    task automatic test_extremes();
        int le, wr, gb, eb;
        exp_pairs.delete(); exp_err.delete();
        gb = got_pairs.size();
        eb = got_err.size();
        slot(1'b0, 32, {32'h0, 16'h8000, 16'hFFFF}, 1'b0, le, wr);
        slot(1'b1, 32, {32'h0, 16'h7FFF, 16'hFFFF}, 1'b0, le, wr);
        repeat (8) @(negedge state_clk);
        n_tests++; if (got_pairs.size() - gb != exp_pairs.size()) begin n_fail++; $display("FAIL extremes_pulses: got %0d expected %0d", got_pairs.size() - gb, exp_pairs.size()); end
        else foreach (exp_pairs[i]) begin
            n_tests++;
            if (got_pairs[gb+i] !== exp_pairs[i]) begin n_fail++; $display("FAIL extremes_pair: got t=%0d l=%h r=%h expected t=%0d l=%h r=%h", got_pairs[gb+i].t, got_pairs[gb+i].l, got_pairs[gb+i].r, exp_pairs[i].t, exp_pairs[i].l, exp_pairs[i].r); end
        end
        n_tests++; if (audio_l !== 16'h8000) begin n_fail++; $display("FAIL extremes_audio_l: got %h expected 8000", audio_l); end
        n_tests++; if (audio_r !== 16'h7FFF) begin n_fail++; $display("FAIL extremes_audio_r: got %h expected 7fff", audio_r); end
        n_tests++; if (got_err.size() != eb) begin n_fail++; $display("FAIL extremes_no_err: got %0d errors expected 0", got_err.size() - eb); end
    endtask

    task automatic test_short_left();
        int le, wr, gb, eb;
        exp_pairs.delete(); exp_err.delete();
        gb = got_pairs.size();
        eb = got_err.size();
        slot(1'b0, 10, 64'h2AA, 1'b0, le, wr);
        slot(1'b1, W, 64'h0001, 1'b0, le, wr);
        slot(1'b0, W, 64'hFFFF, 1'b0, le, wr);
        slot(1'b1, W, 64'h0002, 1'b0, le, wr);
        repeat (8) @(negedge state_clk);
        n_tests++; if (got_err.size() - eb != exp_err.size()) begin n_fail++; $display("FAIL short_errs: got %0d expected %0d", got_err.size() - eb, exp_err.size()); end
        else foreach (exp_err[i]) begin
            n_tests++;
            if (got_err[eb+i] != exp_err[i]) begin n_fail++; $display("FAIL short_err_time: got %0d expected %0d", got_err[eb+i], exp_err[i]); end
        end
        n_tests++; if (got_pairs.size() - gb != exp_pairs.size()) begin n_fail++; $display("FAIL short_pulses: got %0d expected %0d", got_pairs.size() - gb, exp_pairs.size()); end
        else foreach (exp_pairs[i]) begin
            n_tests++;
            if (got_pairs[gb+i] !== exp_pairs[i]) begin n_fail++; $display("FAIL short_pair: got t=%0d l=%h r=%h expected t=%0d l=%h r=%h", got_pairs[gb+i].t, got_pairs[gb+i].l, got_pairs[gb+i].r, exp_pairs[i].t, exp_pairs[i].l, exp_pairs[i].r); end
        end
        n_tests++; if (got_err.size() - eb != 1) begin n_fail++; $display("FAIL short_one_err: got %0d expected 1", got_err.size() - eb); end
        n_tests++; if (audio_l !== 16'hFFFF || audio_r !== 16'h0002) begin n_fail++; $display("FAIL short_audio: got %h/%h expected ffff/0002", audio_l, audio_r); end
    endtask

    task automatic test_reset_mid();
        int le, wr, gb, eb;
        exp_pairs.delete(); exp_err.delete();
        slot(1'b0, W, 64'h1357, 1'b0, le, wr);
        @(negedge state_clk);
        bclk = 1'b0;
        lrck = 1'b1;
        repeat (4) @(negedge state_clk);
        bclk = 1'b1;
        repeat (4) @(negedge state_clk);
        for (int i = 0; i < 7; i++) begin
            bclk = 1'b0;
            adcdat = 1'($urandom);
            repeat (4) @(negedge state_clk);
            bclk = 1'b1;
            repeat (4) @(negedge state_clk);
        end
        bclk = 1'b0;
        adcdat = 1'b1;
        repeat (2) @(negedge state_clk);
        gb = got_pairs.size();
        eb = got_err.size();
        #2 reset = 1'b1;
        #1;
        n_tests++; if (audio_l !== '0) begin n_fail++; $display("FAIL midreset_audio_l: got %h expected 0", audio_l); end
        n_tests++; if (audio_r !== '0) begin n_fail++; $display("FAIL midreset_audio_r: got %h expected 0", audio_r); end
        n_tests++; if (lr_clk !== 1'b0) begin n_fail++; $display("FAIL midreset_lr_clk: got %b expected 0", lr_clk); end
        repeat (3) @(negedge state_clk);
        reset = 1'b0;
        m_trk = 1'b0; m_pend = 1'b0; m_lr = 1'b0; m_short = 1'b0;
        slot(1'b1, W + 1, {$urandom, $urandom}, 1'b0, le, wr);
        n_tests++; if (got_pairs.size() != gb) begin n_fail++; $display("FAIL midreset_no_pulse: got %0d pulses expected 0", got_pairs.size() - gb); end
        slot(1'b0, W, 64'(16'($urandom)), 1'b0, le, wr);
        slot(1'b1, W, 64'(16'($urandom)), 1'b0, le, wr);
        repeat (8) @(negedge state_clk);
        n_tests++; if (got_pairs.size() - gb != exp_pairs.size()) begin n_fail++; $display("FAIL midreset_pulses: got %0d expected %0d", got_pairs.size() - gb, exp_pairs.size()); end
        else foreach (exp_pairs[i]) begin
            n_tests++;
            if (got_pairs[gb+i] !== exp_pairs[i]) begin n_fail++; $display("FAIL midreset_pair: got t=%0d l=%h r=%h expected t=%0d l=%h r=%h", got_pairs[gb+i].t, got_pairs[gb+i].l, got_pairs[gb+i].r, exp_pairs[i].t, exp_pairs[i].l, exp_pairs[i].r); end
        end
        n_tests++; if (got_err.size() != eb) begin n_fail++; $display("FAIL midreset_no_err: got %0d errors expected 0", got_err.size() - eb); end
    endtask

    task automatic test_simul();
        int le0, le1, wr, gb, eb;
        exp_pairs.delete(); exp_err.delete();
        gb = got_pairs.size();
        eb = got_err.size();
        slot(1'b0, W, 64'h5A5A, 1'b1, le0, wr);
        slot(1'b1, W, 64'hA5A5, 1'b1, le1, wr);
        repeat (8) @(negedge state_clk);
        n_tests++; if (got_pairs.size() - gb != exp_pairs.size()) begin n_fail++; $display("FAIL simul_pulses: got %0d expected %0d", got_pairs.size() - gb, exp_pairs.size()); end
        else foreach (exp_pairs[i]) begin
            n_tests++;
            if (got_pairs[gb+i] !== exp_pairs[i]) begin n_fail++; $display("FAIL simul_pair: got t=%0d l=%h r=%h expected t=%0d l=%h r=%h", got_pairs[gb+i].t, got_pairs[gb+i].l, got_pairs[gb+i].r, exp_pairs[i].t, exp_pairs[i].l, exp_pairs[i].r); end
        end
        n_tests++; if (audio_l !== 16'h5A5A || audio_r !== 16'hA5A5) begin n_fail++; $display("FAIL simul_audio: got %h/%h expected 5a5a/a5a5", audio_l, audio_r); end
        n_tests++; if (got_err.size() != eb) begin n_fail++; $display("FAIL simul_no_err: got %0d errors expected 0", got_err.size() - eb); end
        n_tests++; if (lrh[le0] !== 1'b1 || lrh[le0+1] !== 1'b0) begin n_fail++; $display("FAIL simul_lr_clk_fall: got %b%b expected 10", lrh[le0], lrh[le0+1]); end
        n_tests++; if (lrh[le1] !== 1'b0 || lrh[le1+1] !== 1'b1) begin n_fail++; $display("FAIL simul_lr_clk_rise: got %b%b expected 01", lrh[le1], lrh[le1+1]); end
    endtask

    task automatic test_random();
        int le, wr, gb, eb, nb;
        exp_pairs.delete(); exp_err.delete();
        gb = got_pairs.size();
        eb = got_err.size();
        for (int f = 0; f < 24; f++) begin
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W - 1)) : int'($urandom_range(W, W + 6));
            slot(f[0], nb, {$urandom, $urandom}, 1'($urandom_range(0, 1)), le, wr);
        end
        repeat (8) @(negedge state_clk);
        n_tests++; if (got_err.size() - eb != exp_err.size()) begin n_fail++; $display("FAIL random_errs: got %0d expected %0d", got_err.size() - eb, exp_err.size()); end
        else foreach (exp_err[i]) begin
            n_tests++;
            if (got_err[eb+i] != exp_err[i]) begin n_fail++; $display("FAIL random_err_time: got %0d expected %0d", got_err[eb+i], exp_err[i]); end
        end
        n_tests++; if (got_pairs.size() - gb != exp_pairs.size()) begin n_fail++; $display("FAIL random_pulses: got %0d expected %0d", got_pairs.size() - gb, exp_pairs.size()); end
        else foreach (exp_pairs[i]) begin
            n_tests++;
            if (got_pairs[gb+i] !== exp_pairs[i]) begin n_fail++; $display("FAIL random_pair: got t=%0d l=%h r=%h expected t=%0d l=%h r=%h", got_pairs[gb+i].t, got_pairs[gb+i].l, got_pairs[gb+i].r, exp_pairs[i].t, exp_pairs[i].l, exp_pairs[i].r); end
        end
    endtask

    task automatic test_hold();
        n_tests++; if (dbl != 0) begin n_fail++; $display("FAIL hold_single_pulse: got %0d back-to-back pulses expected 0", dbl); end
        n_tests++; if (hold_bad != 0) begin n_fail++; $display("FAIL hold_outputs: got %0d unstrobed changes expected 0", hold_bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_short_left();
        test_reset_mid();
        test_simul();
        test_random();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_adc_deserializer.md
# audio_adc_deserializer

Receives the codec's I2S ADC serial stream (bit clock, word-select, serial data) and turns it into parallel signed left/right samples. All codec signals are oversampled on the fast `state_clk` domain. The block sits directly upstream of the fourth-order IIR filter. It supplies that filter's `audio_in` sample and a synchronized `lr_clk`, and emits a one-cycle strobe whenever a complete stereo pair is available.

## Interface
- `WIDTH`, 16: bits captured per channel, MSB first. Any bits beyond WIDTH in a slot are ignored.
- `state_clk` in 1: system clock; must run at least 4× `bclk`.
- `reset` in 1: asynchronous, active-high; all state returns to reset values.
- `bclk` in 1: codec bit clock, asynchronous to `state_clk`.
- `lrck` in 1: codec word select; 0 = left slot, 1 = right slot.
- `adcdat` in 1: codec serial data, valid on rising `bclk`.
- `audio_l` out WIDTH (signed): last complete left sample.
- `audio_r` out WIDTH (signed): last complete right sample.
- `sample_valid` out 1: one-cycle pulse when `audio_l`/`audio_r` update.
- `lr_clk` out 1: synchronized `lrck`; drives the filter's `lr_clk`.
- `frame_err` out 1: one-cycle pulse when a slot ends before WIDTH bits are captured.

## Operation
- **Synchronizers:** `bclk`, `lrck` and `adcdat` each pass through a 3-flop chain (s1, s2, s3).
- **Edge detection:**
  - bclk rise = bclk_s2 & ~bclk_s3.
  - lrck edge = lrck_s2 ^ lrck_s3.
  - Data bit used = adcdat_s2.
- **`lr_clk` output:** `lr_clk` = lrck_s2.
- **State machine:** IDLE, SKIP, SHIFT, WAIT.
  - **IDLE** (after reset): on an lrck edge, go to SKIP; clear the bit counter and the shift register. The first partial slot after reset is always discarded.
  - **SKIP:** the first bclk rise after the lrck edge is the I2S one-bit delay. Discard that bit and go to SHIFT.
  - **SHIFT:** on each bclk rise, shift reg = {shift[WIDTH-2:0], adcdat_s2} and increment the counter. When the rise carrying bit WIDTH-1 arrives, go to WAIT and complete the word:
    - Current slot left (lrck_s3 = 0): left_hold ← word; set left_ok.
    - Current slot right (lrck_s3 = 1) with left_ok = 1: `audio_l` ← left_hold, `audio_r` ← word, `sample_valid` = 1 for one cycle; clear left_ok.
    - Current slot right with left_ok = 0: discard the word silently.
  - **WAIT:** ignore all bclk rises. On an lrck edge, go to SKIP.
- **Short slot:** an lrck edge while in SKIP or SHIFT means the slot was short.
  - Pulse `frame_err` for one cycle.
  - Discard the partial word.
  - If the aborted slot was left, clear left_ok.
  - Go to SKIP for the new slot.
- **Edge priority:** if an lrck edge and a bclk rise are detected in the same cycle, the lrck edge wins and that bclk rise is treated as the delay bit of the new slot. The next state is SHIFT, not SKIP.
- **Arithmetic:** none. Samples are passed through bit-exact as two's complement.

## Timing
- **Reset values:** `audio_l` = 0, `audio_r` = 0, `sample_valid` = 0, `frame_err` = 0, `lr_clk` = 0. Internally: state = IDLE, left_ok = 0, counter = 0.
- **Latency:** let edge N be the `state_clk` edge at which bclk_s1 first registers the final right-slot bit's rising `bclk`. `audio_l`, `audio_r` and `sample_valid` update at edge N+2.
- **Hold:** outputs hold their values until the next valid pair. `sample_valid` is never high on two consecutive cycles.
- **`frame_err` timing:** asserts at edge L+2, where L is the edge at which lrck_s1 captures the early transition.
- **Reset mid-word:** asynchronous assertion immediately forces the reset values. After release, the block waits in IDLE for the next lrck edge, so no sample from the interrupted frame is emitted.
- **Input constraints:** each `bclk` high and low phase must last at least 2 `state_clk` periods. `adcdat` must be stable around rising `bclk`.

## Test plan
- **Reset values:** assert `reset` asynchronously with clocks running → all outputs 0 within the same cycle; after release, no `sample_valid` until one full frame following an lrck edge.
- **Basic I2S frame:** `state_clk` = 8× `bclk`, WIDTH = 16, 16-bit slots, L = 0x1234, R = 0xABCD → exactly one `sample_valid` pulse with `audio_l` = 0x1234 and `audio_r` = 0xABCD, at edge N+2 relative to the last right bit.
- **Extremes and padding:** 32-bit slots, L = 0x8000, R = 0x7FFF, 16 pad bits of 1 → `audio_l` = 0x8000, `audio_r` = 0x7FFF; padding ignored; no `frame_err`.
- **Short left slot:** left slot of 10 bits, then a good right slot (0x0001), then a good frame (L = 0xFFFF, R = 0x0002) →
  - one `frame_err` pulse;
  - no `sample_valid` for the damaged pair;
  - next pulse carries 0xFFFF / 0x0002.
- **Reset mid-word:** assert `reset` during bit 7 of the right slot → outputs return to 0 and no pulse is emitted for that frame; the next full frame is received correctly.
- **Simultaneous edges:** lrck transition coincident with a bclk rise, L = 0x5A5A, R = 0xA5A5 → captured correctly and `lr_clk` tracks `lrck` with 2-cycle lag.
